// File: rtl/contador_pkg.sv
// Shared constants for the up/down counter: press-FSM state encodings,
// step direction constants and a small elaboration-time helper.
// Configuration macro: CONTADOR_AUTOREPEAT_EN (consumed by contador_press_fsm).
package contador_pkg;

    localparam logic [1:0] ST_ARMED  = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    typedef enum logic [1:0] {
        ARMED  = ST_ARMED,
        HELD   = ST_HELD,
        REPEAT = ST_REPEAT
    } state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Larger of two unsigned values, used to size the hold/repeat timer.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/contador_press_fsm.sv
// Turns up/down button levels into single-cycle step strobes.
// One step per press; with CONTADOR_AUTOREPEAT_EN defined, a held button
// repeats after HOLD_CYCLES and then every REPEAT_CYCLES.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   up, down        button levels (synchronous to clk)
//   step_c          combinational one-cycle step strobe
//   step_dir_c      combinational step direction (DIR_UP / DIR_DN)
module contador_press_fsm
    import contador_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic up,
    input  logic down,
    output logic step_c,
    output logic step_dir_c
);

    state_t state;
    state_t state_nxt;
    logic   dir_q;
    logic   dir_nxt;
    logic   req;
    logic   dir;
    logic   press;

`ifdef CONTADOR_AUTOREPEAT_EN
    localparam int unsigned TMR_W = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES) + 1);
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nxt;
`endif

    // State, latched direction and timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARMED;
            dir_q <= DIR_UP;
`ifdef CONTADOR_AUTOREPEAT_EN
            tmr   <= '0;
`endif
        end else begin
            state <= state_nxt;
            dir_q <= dir_nxt;
`ifdef CONTADOR_AUTOREPEAT_EN
            tmr   <= tmr_nxt;
`endif
        end
    end

    assign req = up ^ down;
    assign dir = down;
    // A press is a request from ARMED, or a direction reversal while held.
    assign press = req && ((state == ARMED) || (dir != dir_q));

    // Next-state and step strobe.
    always_comb begin
        state_nxt  = state;
        dir_nxt    = dir_q;
        step_c     = 1'b0;
        step_dir_c = dir_q;
`ifdef CONTADOR_AUTOREPEAT_EN
        tmr_nxt    = tmr;
`endif
        if (!req) begin
            state_nxt = ARMED;
`ifdef CONTADOR_AUTOREPEAT_EN
            tmr_nxt   = '0;
`endif
        end else if (press) begin
            step_c     = 1'b1;
            step_dir_c = dir;
            dir_nxt    = dir;
            state_nxt  = HELD;
`ifdef CONTADOR_AUTOREPEAT_EN
            tmr_nxt    = '0;
`endif
        end else begin
`ifdef CONTADOR_AUTOREPEAT_EN
            // Timer value k-1 before edge k; step when the interval elapses.
            case (state)
                HELD: begin
                    if (tmr == TMR_W'(HOLD_CYCLES - 1)) begin
                        step_c    = 1'b1;
                        state_nxt = REPEAT;
                        tmr_nxt   = '0;
                    end else begin
                        tmr_nxt = tmr + TMR_W'(1);
                    end
                end
                REPEAT: begin
                    if (tmr == TMR_W'(REPEAT_CYCLES - 1)) begin
                        step_c  = 1'b1;
                        tmr_nxt = '0;
                    end else begin
                        tmr_nxt = tmr + TMR_W'(1);
                    end
                end
                default: begin
                    tmr_nxt = '0;
                end
            endcase
`endif
        end
    end

endmodule

// File: rtl/contador_updown_n.sv
// Parametrised up/down counter with wrap/saturate range handling,
// clamped synchronous load and boundary flags.
// Optional hold-to-repeat enabled by macro CONTADOR_AUTOREPEAT_EN.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   up, down     button levels
//   load         synchronous load strobe, load_val the value (clamped)
//   mode_sat     0 = wrap at range ends, 1 = saturate
//   curr_numero  registered count
//   wrap_pulse   registered one-cycle pulse on a wrapping step
//   at_min       curr_numero == MIN_VAL (decoded from register)
//   at_max       curr_numero == MAX_VAL (decoded from register)
module contador_updown_n
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned MIN_VAL       = 0,
    parameter int unsigned MAX_VAL       = (1 << WIDTH) - 1,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode_sat,
    output logic [WIDTH-1:0] curr_numero,
    output logic             wrap_pulse,
    output logic             at_min,
    output logic             at_max
);

    localparam int unsigned XW = WIDTH + 1;
    localparam logic [WIDTH:0]   MIN_X = XW'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_X = XW'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic             step_c;
    logic             step_dir_c;
    logic [WIDTH:0]   cur_x;
    logic [WIDTH:0]   inc_x;
    logic [WIDTH:0]   dec_x;
    logic [WIDTH:0]   lv_x;
    logic [WIDTH-1:0] nxt_numero;
    logic             nxt_wrap;

    contador_press_fsm #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_press (
        .clk       (clk),
        .rst       (rst),
        .up        (up),
        .down      (down),
        .step_c    (step_c),
        .step_dir_c(step_dir_c)
    );

    // Range arithmetic one bit wider so MAX_VAL = 2**WIDTH-1 cannot overflow.
    always_comb begin
        nxt_numero = curr_numero;
        nxt_wrap   = 1'b0;
        cur_x      = {1'b0, curr_numero};
        inc_x      = cur_x + XW'(1);
        dec_x      = cur_x - XW'(1);
        lv_x       = {1'b0, load_val};
        if (load) begin
            // Load wins over a same-cycle step; the FSM still advances.
            if (lv_x < MIN_X) begin
                nxt_numero = MIN_W;
            end else if (lv_x > MAX_X) begin
                nxt_numero = MAX_W;
            end else begin
                nxt_numero = load_val;
            end
        end else if (step_c) begin
            if (step_dir_c == DIR_UP) begin
                if (inc_x > MAX_X) begin
                    nxt_numero = mode_sat ? MAX_W : MIN_W;
                    nxt_wrap   = !mode_sat;
                end else begin
                    nxt_numero = inc_x[WIDTH-1:0];
                end
            end else begin
                // Borrow out of the top bit also means we left the range.
                if (dec_x[WIDTH] || (dec_x < MIN_X)) begin
                    nxt_numero = mode_sat ? MIN_W : MAX_W;
                    nxt_wrap   = !mode_sat;
                end else begin
                    nxt_numero = dec_x[WIDTH-1:0];
                end
            end
        end
    end

    // Count and wrap pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curr_numero <= MIN_W;
            wrap_pulse  <= 1'b0;
        end else begin
            curr_numero <= nxt_numero;
            wrap_pulse  <= nxt_wrap;
        end
    end

    assign at_min = (curr_numero == MIN_W);
    assign at_max = (curr_numero == MAX_W);

endmodule

// File: tb/tb_contador_updown_n.sv
// Scoreboard bench for contador_updown_n (WIDTH=4, range 2..9, HOLD=8, REPEAT=3).
// Expectations follow CONTADOR_AUTOREPEAT_EN when it is defined for the build.
module tb_contador_updown_n;

    logic       clk;
    logic       rst;
    logic       up;
    logic       down;
    logic       load;
    logic [3:0] load_val;
    logic       mode_sat;
    logic [3:0] curr_numero;
    logic       wrap_pulse;
    logic       at_min;
    logic       at_max;

    typedef struct {
        logic [3:0] val;
        logic       wrap;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    contador_updown_n #(
        .WIDTH        (4),
        .MIN_VAL      (2),
        .MAX_VAL      (9),
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up         (up),
        .down       (down),
        .load       (load),
        .load_val   (load_val),
        .mode_sat   (mode_sat),
        .curr_numero(curr_numero),
        .wrap_pulse (wrap_pulse),
        .at_min     (at_min),
        .at_max     (at_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [3:0] ev, input logic ew);
        check({nm, ".val"}, int'(curr_numero), int'(ev));
        check({nm, ".wrap"}, int'(wrap_pulse), int'(ew));
        check({nm, ".at_min"}, int'(at_min), (ev == 4'd2) ? 1 : 0);
        check({nm, ".at_max"}, int'(at_max), (ev == 4'd9) ? 1 : 0);
    endtask

    // Drive one cycle's inputs (called at a negedge) and queue the post-edge state.
    task automatic cyc(input logic u, input logic d, input logic l, input logic [3:0] lv,
                       input logic [3:0] ev, input logic ew, input string nm);
        exp_t e;
        up = u; down = d; load = l; load_val = lv;
        e.val = ev; e.wrap = ew; e.name = nm;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Hand-derived hold schedule: steps at hold cycles 0, 8, 11, 14, 17.
    function automatic int held_steps(input int i);
`ifdef CONTADOR_AUTOREPEAT_EN
        return 1 + ((i >= 8) ? 1 : 0) + ((i >= 11) ? 1 : 0) + ((i >= 14) ? 1 : 0) + ((i >= 17) ? 1 : 0);
`else
        return 1;
`endif
    endfunction

    // Monitor: every clock the DUT presents a new state; compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_all(e.name, e.val, e.wrap);
            end
        end
    end

    initial begin
        int drain;
        rst = 1'b1; up = 1'b0; down = 1'b0; load = 1'b0; load_val = 4'd0; mode_sat = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all("reset", 4'd2, 1'b0);
        rst = 1'b0;

        // Single presses with release in between.
        cyc(1, 0, 0, 0, 4'd3, 0, "up1");
        cyc(0, 0, 0, 0, 4'd3, 0, "rel1");
        cyc(1, 0, 0, 0, 4'd4, 0, "up2");
        cyc(0, 0, 0, 0, 4'd4, 0, "rel2");
        cyc(1, 0, 0, 0, 4'd5, 0, "up3");
        cyc(1, 0, 0, 0, 4'd5, 0, "up3_held");
        cyc(0, 0, 0, 0, 4'd5, 0, "rel3");
        cyc(0, 1, 0, 0, 4'd4, 0, "dn1");
        cyc(0, 0, 0, 0, 4'd4, 0, "rel4");
        cyc(1, 1, 0, 0, 4'd4, 0, "both1");
        cyc(1, 1, 0, 0, 4'd4, 0, "both2");
        cyc(0, 0, 0, 0, 4'd4, 0, "rel5");

        // Wrap mode at both ends.
        cyc(0, 0, 1, 4'd9, 4'd9, 0, "ld9");
        cyc(1, 0, 0, 0, 4'd2, 1, "wrap_up");
        cyc(0, 0, 0, 0, 4'd2, 0, "wrap_up_end");
        cyc(0, 1, 0, 0, 4'd9, 1, "wrap_dn");
        cyc(0, 0, 0, 0, 4'd9, 0, "wrap_dn_end");

        // Saturate mode at both ends.
        mode_sat = 1'b1;
        cyc(1, 0, 0, 0, 4'd9, 0, "sat_up");
        cyc(0, 0, 0, 0, 4'd9, 0, "sat_up_rel");
        cyc(0, 0, 1, 4'd2, 4'd2, 0, "ld2");
        cyc(0, 1, 0, 0, 4'd2, 0, "sat_dn");
        cyc(0, 0, 0, 0, 4'd2, 0, "sat_dn_rel");
        mode_sat = 1'b0;

        // Load clamping and load overriding a step.
        cyc(0, 0, 1, 4'd15, 4'd9, 0, "ld_clamp_hi");
        cyc(0, 0, 1, 4'd0, 4'd2, 0, "ld_clamp_lo");
        cyc(0, 0, 1, 4'd5, 4'd5, 0, "ld5");
        cyc(1, 0, 1, 4'd7, 4'd7, 0, "ld_over_up");
        cyc(1, 0, 0, 0, 4'd7, 0, "ld_over_held");
        cyc(0, 0, 0, 0, 4'd7, 0, "ld_over_rel");

        // Long hold, then reversal without release.
        cyc(0, 0, 1, 4'd2, 4'd2, 0, "ld2_rep");
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, 0, 4'(2 + held_steps(i)), 0, $sformatf("hold%0d", i));
        end
        cyc(0, 1, 0, 0, 4'(1 + held_steps(19)), 0, "reverse");
        cyc(0, 0, 0, 0, 4'(1 + held_steps(19)), 0, "reverse_rel");

        // Asynchronous reset in the middle of a hold, button kept down.
        cyc(0, 0, 1, 4'd2, 4'd2, 0, "ld2_rst");
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 0, 0, 4'(2 + held_steps(i)), 0, $sformatf("hold_b%0d", i));
        end
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 4'd2, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 0, 0, 0, 4'd3, 0, "post_rst");
        cyc(0, 0, 0, 0, 4'd3, 0, "post_rst_rel");

        drain = 0;
        while (q.size() > 0 && drain < 100) begin
            @(negedge clk);
            drain++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
